// File: rtl/csr_counter_unit_if.sv
// CSR access and memory-mapped timer port bundle for csr_counter_unit.
// The master issues CSR/timer requests; the slave is the counter unit.
interface csr_counter_unit_if;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_hit;
   logic        csr_illegal;
   logic        tmr_req;
   logic        tmr_we;
   logic [1:0]  tmr_addr;
   logic [31:0] tmr_wdata;
   logic        tmr_ack;
   logic [31:0] tmr_rdata;

   modport master (
      output csr_we, csr_addr, csr_wdata,
      input  csr_rdata, csr_hit, csr_illegal,
      output tmr_req, tmr_we, tmr_addr, tmr_wdata,
      input  tmr_ack, tmr_rdata
   );

   modport slave (
      input  csr_we, csr_addr, csr_wdata,
      output csr_rdata, csr_hit, csr_illegal,
      input  tmr_req, tmr_we, tmr_addr, tmr_wdata,
      output tmr_ack, tmr_rdata
   );
endinterface

// File: rtl/csr_counter_unit.sv
// Machine counters (mcycle, minstret, mtime/mtimecmp, mcountinhibit)
// with CSR access, a memory-mapped timer port and a registered mtip.
module csr_counter_unit #(
   parameter int unsigned TIMER_DIV     = 1,
   parameter logic [63:0] MTIMECMP_INIT = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   csr_counter_unit_if.slave bus,
   input  logic [1:0]        retire_cnt,
   output logic              mtip
);

   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MCNTINH   = 12'h320;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_TIME      = 12'hC01;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_TIMEH     = 12'hC81;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;

   localparam logic [15:0] PRESC_MAX = 16'(TIMER_DIV - 1);

   logic [63:0] mcycle;
   logic [63:0] minstret;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [15:0] presc;
   logic        inh_cy;
   logic        inh_ir;

   logic        ro_addr;
   logic        wr_ok;
   logic        wr_cyc_lo;
   logic        wr_cyc_hi;
   logic        wr_ins_lo;
   logic        wr_ins_hi;
   logic        wr_inh;
   logic [63:0] ins_inc;
   logic        t_wr;
   logic [31:0] tmr_rd;

   always_comb begin
      bus.csr_rdata = '0;
      bus.csr_hit   = 1'b1;
      ro_addr       = 1'b0;
      case (bus.csr_addr)
         A_MCYCLE:    bus.csr_rdata = mcycle[31:0];
         A_MCYCLEH:   bus.csr_rdata = mcycle[63:32];
         A_MINSTRET:  bus.csr_rdata = minstret[31:0];
         A_MINSTRETH: bus.csr_rdata = minstret[63:32];
         A_MCNTINH:   bus.csr_rdata = {29'b0, inh_ir, 1'b0, inh_cy};
         A_CYCLE: begin
            bus.csr_rdata = mcycle[31:0];
            ro_addr       = 1'b1;
         end
         A_TIME: begin
            bus.csr_rdata = mtime[31:0];
            ro_addr       = 1'b1;
         end
         A_INSTRET: begin
            bus.csr_rdata = minstret[31:0];
            ro_addr       = 1'b1;
         end
         A_CYCLEH: begin
            bus.csr_rdata = mcycle[63:32];
            ro_addr       = 1'b1;
         end
         A_TIMEH: begin
            bus.csr_rdata = mtime[63:32];
            ro_addr       = 1'b1;
         end
         A_INSTRETH: begin
            bus.csr_rdata = minstret[63:32];
            ro_addr       = 1'b1;
         end
         default: bus.csr_hit = 1'b0;
      endcase
   end

   assign bus.csr_illegal = bus.csr_we & ro_addr;

   // Writes to read-only shadows are flagged and otherwise ignored.
   assign wr_ok     = bus.csr_we & ~ro_addr;
   assign wr_cyc_lo = wr_ok & (bus.csr_addr == A_MCYCLE);
   assign wr_cyc_hi = wr_ok & (bus.csr_addr == A_MCYCLEH);
   assign wr_ins_lo = wr_ok & (bus.csr_addr == A_MINSTRET);
   assign wr_ins_hi = wr_ok & (bus.csr_addr == A_MINSTRETH);
   assign wr_inh    = wr_ok & (bus.csr_addr == A_MCNTINH);

   // A retire count of 3 saturates to 2.
   assign ins_inc = {62'b0, retire_cnt[1], retire_cnt[0] & ~retire_cnt[1]};

   assign t_wr = bus.tmr_req & bus.tmr_we;

   always_comb begin
      tmr_rd = '0;
      unique case (bus.tmr_addr)
         2'd0: tmr_rd = mtime[31:0];
         2'd1: tmr_rd = mtime[63:32];
         2'd2: tmr_rd = mtimecmp[31:0];
         2'd3: tmr_rd = mtimecmp[63:32];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcycle        <= '0;
         minstret      <= '0;
         mtime         <= '0;
         mtimecmp      <= MTIMECMP_INIT;
         presc         <= '0;
         inh_cy        <= 1'b0;
         inh_ir        <= 1'b0;
         mtip          <= 1'b0;
         bus.tmr_ack   <= 1'b0;
         bus.tmr_rdata <= '0;
      end else begin
         if (wr_cyc_lo)
            mcycle <= {mcycle[63:32], bus.csr_wdata};
         else if (wr_cyc_hi)
            mcycle <= {bus.csr_wdata, mcycle[31:0]};
         else if (!inh_cy)
            mcycle <= mcycle + 64'd1;

         if (wr_ins_lo)
            minstret <= {minstret[63:32], bus.csr_wdata};
         else if (wr_ins_hi)
            minstret <= {bus.csr_wdata, minstret[31:0]};
         else if (!inh_ir)
            minstret <= minstret + ins_inc;

         if (wr_inh) begin
            inh_cy <= bus.csr_wdata[0];
            inh_ir <= bus.csr_wdata[2];
         end

         // A port write to mtime also restarts the prescaler.
         if (t_wr && bus.tmr_addr == 2'd0) begin
            mtime <= {mtime[63:32], bus.tmr_wdata};
            presc <= '0;
         end else if (t_wr && bus.tmr_addr == 2'd1) begin
            mtime <= {bus.tmr_wdata, mtime[31:0]};
            presc <= '0;
         end else if (presc == PRESC_MAX) begin
            mtime <= mtime + 64'd1;
            presc <= '0;
         end else begin
            presc <= presc + 16'd1;
         end

         if (t_wr && bus.tmr_addr == 2'd2)
            mtimecmp <= {mtimecmp[63:32], bus.tmr_wdata};
         if (t_wr && bus.tmr_addr == 2'd3)
            mtimecmp <= {bus.tmr_wdata, mtimecmp[31:0]};

         mtip        <= (mtime >= mtimecmp);
         bus.tmr_ack <= bus.tmr_req;
         if (bus.tmr_req && !bus.tmr_we)
            bus.tmr_rdata <= tmr_rd;
      end
   end

endmodule
